frv_dmem_arb: RTL and testbench
===============================

Name: frv_dmem_arb

Overview:
Two-requester arbiter that shares the single core data-memory port between the load/store unit (port m0) and a secondary bus master (port m1, e.g. a debug/DMA/accelerator master).
- Request channel: req/gnt. Response channel: recv/ack/error, same protocol as the core dmem bus.
- Sits between the LSU and the external dmem interface.
- Tracks in-order outstanding transactions so each response is routed to the requester that issued it.

Parameters:
XL, 31, data/address MSB index (codebase constant from common header)
MAX_OUT, 2, maximum outstanding granted-but-unanswered transactions (power of two, >=1)

Ports:
g_clk  in  1  global clock
g_reset  in  1  synchronous reset, active-high
m0_req  in  1  LSU request
m0_wen  in  1  LSU write enable
m0_strb  in  4  LSU byte strobe
m0_addr  in  XL+1  LSU word address
m0_wdata  in  XL+1  LSU write data
m0_gnt  out  1  LSU request accepted
m0_recv  out  1  LSU response valid
m0_ack  in  1  LSU accepts response
m0_error  out  1  LSU response error
m0_rdata  out  XL+1  LSU read data
m1_*  same set as m0_*  secondary master
dmem_req  out  1  downstream request
dmem_wen  out  1  downstream write enable
dmem_strb  out  4  downstream strobe
dmem_addr  out  XL+1  downstream address
dmem_wdata  out  XL+1  downstream write data
dmem_gnt  in  1  downstream accepted
dmem_recv  in  1  downstream response valid
dmem_ack  out  1  response accepted
dmem_error  in  1  downstream error
dmem_rdata  in  XL+1  downstream read data

Behaviour:
- Reset (g_reset=1 at posedge): lock state IDLE, owner FIFO empty, RR pointer = m0. All outputs are combinational from state; after reset with no inputs asserted, every output is 0.
- Request FSM states:
  - IDLE: select a requester combinationally, same cycle, zero added latency. dmem_* request fields mux from the selected master.
  - If dmem_gnt is low while the selected req is high, next state is LOCK0/LOCK1 matching the selection.
  - LOCK0/LOCK1: the selection is held regardless of the other master, so address and data stay stable.
  - Return to IDLE on the cycle dmem_req && dmem_gnt, or if the locked master drops req (protocol violation; the request is abandoned, not forwarded).
- mX_gnt = dmem_gnt && dmem_req && sel==X. The unselected master sees gnt=0.
- Owner FIFO (depth MAX_OUT, 1-bit entries):
  - Push the selected ID on dmem_req && dmem_gnt.
  - Pop on dmem_recv && dmem_ack.
  - Push and pop in the same cycle are both performed; count is unchanged.
- FIFO full: dmem_req is forced to 0 (no new grant), including in a cycle where a pop occurs. The lock state is kept.
- Response routing:
  - head = FIFO head ID. mX_recv = dmem_recv && !empty && head==X.
  - mX_rdata and mX_error carry dmem_rdata/dmem_error when routed, and are 0 otherwise.
  - dmem_ack = the head owner's ack.
- dmem_recv while FIFO empty: spurious. dmem_ack=1 so it is drained; nothing is forwarded.
- Write responses are tracked identically to reads.
- Reset mid-transaction: lock and FIFO are cleared. Any in-flight response arriving afterwards is treated as spurious.

Optional Feature:
FRV_DMEM_ARB_RR_EN
- Defined: round-robin selection in IDLE. A 1-bit pointer names the preferred master; it toggles to the other master after each grant to the preferred one. With single requests, the requester wins regardless of the pointer.
- Undefined: fixed priority, m0 (LSU) always wins simultaneous requests in IDLE. No pointer flop.

Decomposition:
- Shared package/header: requester ID constants (ARB_ID_LSU=0, ARB_ID_AUX=1) and lock-state encodings (IDLE=2'd0, LOCK0=2'd1, LOCK1=2'd2).
- Sub-module: frv_dmem_arb_fifo, a parameterised MAX_OUT-deep 1-bit synchronous FIFO with push, pop, full, empty and head outputs.

Test Plan:
- m0 and m1 both request in the same cycle, dmem_gnt=1, fixed priority -> m0_gnt=1, m1_gnt=0. Next cycle m1_gnt=1; responses route m0 then m1.
- m1 requests at addr 0x100 with dmem_gnt held 0 for 3 cycles while m0 asserts req -> dmem_addr stays 0x100 and state is LOCK1. On gnt, m1_gnt=1; the following cycle m0 is selected.
- MAX_OUT=2: issue 2 grants with no response -> third request sees dmem_req=0. Then recv with ack -> dmem_req reasserts the next cycle.
- Response to m0 with dmem_error=1 and rdata 0xDEADBEEF -> m0_recv=1, m0_error=1, m0_rdata=0xDEADBEEF, m1_recv=0. m0_ack=0 holds the FIFO head until ack.
- g_reset asserted while 1 transaction is outstanding and LOCK0 is active -> next cycle state is IDLE, FIFO is empty, all outputs 0. A later dmem_recv produces dmem_ack=1 with no mX_recv.
- FRV_DMEM_ARB_RR_EN defined, both masters requesting continuously with gnt=1 -> grants alternate m0, m1, m0, m1.

Source files
------------

// File: rtl/frv_dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// frv_dmem_arb_pkg
// Shared constants for the data-memory arbiter: requester IDs, the request
// lock-state encoding and the default data/address MSB index.
// -----------------------------------------------------------------------------
package frv_dmem_arb_pkg;

  // Data/address MSB index used across the core.
  localparam int ARB_XL = 31;

  // Requester IDs stored in the owner FIFO.
  localparam logic ARB_ID_LSU = 1'b0;
  localparam logic ARB_ID_AUX = 1'b1;

  // Request-side lock state.
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_LOCK0 = 2'd1,
    ARB_LOCK1 = 2'd2
  } arb_state_t;

  // Lock state that holds the given requester.
  function automatic arb_state_t arb_lock_of(input logic id);
    return (id == ARB_ID_AUX) ? ARB_LOCK1 : ARB_LOCK0;
  endfunction

endpackage

// File: rtl/frv_dmem_arb_fifo.sv
// -----------------------------------------------------------------------------
// frv_dmem_arb_fifo
// MAX_OUT-deep, 1-bit wide synchronous FIFO holding the owner ID of every
// granted-but-unanswered transaction, oldest at the head.
//
// Ports:
//   clk, rst  : clock, synchronous active-high reset (pointers/count only)
//   push      : write push_id (caller guarantees !full or a same-cycle pop)
//   pop       : drop the head entry (caller guarantees !empty)
//   push_id   : requester ID to enqueue
//   full      : MAX_OUT entries held
//   empty     : no entries held
//   head      : ID at the head (meaningless while empty)
// -----------------------------------------------------------------------------
module frv_dmem_arb_fifo #(
  parameter int MAX_OUT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic push_id,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int AW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CW = $clog2(MAX_OUT + 1);

  logic          mem [MAX_OUT];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(MAX_OUT - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      // Simultaneous push and pop leave the occupancy unchanged.
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Storage carries no reset; emptiness is tracked by the count alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_id;
  end

  assign full  = (count == CW'(MAX_OUT));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/frv_dmem_arb.sv
// -----------------------------------------------------------------------------
// frv_dmem_arb
// Shares the core data-memory port between the LSU (m0) and a secondary
// master (m1). Requests use req/gnt; responses use recv/ack/error. An owner
// FIFO records who was granted, in order, so each response is routed back to
// its issuer.
//
// Build option:
//   FRV_DMEM_ARB_RR_EN  defined   -> round-robin choice in IDLE (1-bit pointer)
//                       undefined -> fixed priority, m0 wins ties
//
// Ports:
//   g_clk, g_reset                : clock, synchronous active-high reset
//   mX_req/wen/strb/addr/wdata    : master request fields (X = 0, 1)
//   mX_gnt                        : master request accepted downstream
//   mX_recv/error/rdata           : response routed to master X (0 otherwise)
//   mX_ack                        : master accepts its response
//   dmem_req/wen/strb/addr/wdata  : downstream request
//   dmem_gnt                      : downstream accepted request
//   dmem_recv/error/rdata         : downstream response
//   dmem_ack                      : response accepted by the head owner
// -----------------------------------------------------------------------------
module frv_dmem_arb
  import frv_dmem_arb_pkg::*;
#(
  parameter int XL      = ARB_XL,
  parameter int MAX_OUT = 2
) (
  input  logic          g_clk,
  input  logic          g_reset,

  input  logic          m0_req,
  input  logic          m0_wen,
  input  logic [3:0]    m0_strb,
  input  logic [XL:0]   m0_addr,
  input  logic [XL:0]   m0_wdata,
  output logic          m0_gnt,
  output logic          m0_recv,
  input  logic          m0_ack,
  output logic          m0_error,
  output logic [XL:0]   m0_rdata,

  input  logic          m1_req,
  input  logic          m1_wen,
  input  logic [3:0]    m1_strb,
  input  logic [XL:0]   m1_addr,
  input  logic [XL:0]   m1_wdata,
  output logic          m1_gnt,
  output logic          m1_recv,
  input  logic          m1_ack,
  output logic          m1_error,
  output logic [XL:0]   m1_rdata,

  output logic          dmem_req,
  output logic          dmem_wen,
  output logic [3:0]    dmem_strb,
  output logic [XL:0]   dmem_addr,
  output logic [XL:0]   dmem_wdata,
  input  logic          dmem_gnt,
  input  logic          dmem_recv,
  output logic          dmem_ack,
  input  logic          dmem_error,
  input  logic [XL:0]   dmem_rdata
);

  arb_state_t state;
  arb_state_t state_nxt;

  logic idle_sel;
  logic sel;
  logic sel_req;
  logic accept;
  logic pop;
  logic fifo_full;
  logic fifo_empty;
  logic fifo_head;
  logic route0;
  logic route1;

  // IDLE selection: a lone requester always wins; ties go to the pointer
  // (round-robin) or to the LSU (fixed priority).
`ifdef FRV_DMEM_ARB_RR_EN
  logic rr_ptr;

  assign idle_sel = (m0_req && m1_req) ? rr_ptr : m1_req;

  // The preferred master yields its preference once it has been granted.
  always_ff @(posedge g_clk) begin
    if (g_reset)                     rr_ptr <= ARB_ID_LSU;
    else if (accept && sel == rr_ptr) rr_ptr <= ~rr_ptr;
  end
`else
  assign idle_sel = m1_req && !m0_req;
`endif

  always_ff @(posedge g_clk) begin
    if (g_reset) state <= ARB_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    sel       = idle_sel;
    state_nxt = state;
    case (state)
      ARB_LOCK0: sel = ARB_ID_LSU;
      ARB_LOCK1: sel = ARB_ID_AUX;
      default:   sel = idle_sel;
    endcase

    sel_req = sel ? m1_req : m0_req;
    // A full owner FIFO blocks new grants but the selection stays held.
    dmem_req = sel_req && !fifo_full;
    accept   = dmem_req && dmem_gnt;

    case (state)
      ARB_IDLE: begin
        if (sel_req && !accept) state_nxt = arb_lock_of(sel);
      end
      ARB_LOCK0, ARB_LOCK1: begin
        // A locked master that drops req abandons the request.
        if (!sel_req || accept) state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  assign dmem_wen   = sel ? m1_wen   : m0_wen;
  assign dmem_strb  = sel ? m1_strb  : m0_strb;
  assign dmem_addr  = sel ? m1_addr  : m0_addr;
  assign dmem_wdata = sel ? m1_wdata : m0_wdata;

  assign m0_gnt = accept && (sel == ARB_ID_LSU);
  assign m1_gnt = accept && (sel == ARB_ID_AUX);

  // Responses with no recorded owner are drained by acking them here.
  assign dmem_ack = fifo_empty ? dmem_recv
                               : (fifo_head ? m1_ack : m0_ack);
  assign pop      = dmem_recv && dmem_ack && !fifo_empty;

  assign route0 = dmem_recv && !fifo_empty && (fifo_head == ARB_ID_LSU);
  assign route1 = dmem_recv && !fifo_empty && (fifo_head == ARB_ID_AUX);

  assign m0_recv  = route0;
  assign m0_error = route0 && dmem_error;
  assign m0_rdata = route0 ? dmem_rdata : '0;
  assign m1_recv  = route1;
  assign m1_error = route1 && dmem_error;
  assign m1_rdata = route1 ? dmem_rdata : '0;

  frv_dmem_arb_fifo #(
    .MAX_OUT (MAX_OUT)
  ) u_fifo (
    .clk     (g_clk),
    .rst     (g_reset),
    .push    (accept),
    .pop     (pop),
    .push_id (sel),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (fifo_head)
  );

endmodule

// File: tb/tb_frv_dmem_arb.sv
// -----------------------------------------------------------------------------
// tb_frv_dmem_arb
// Self-checking bench for frv_dmem_arb: directed scenarios followed by random
// traffic, every cycle compared against a transaction-level reference model
// (owner queue, held master, round-robin preference).
// -----------------------------------------------------------------------------
module tb_frv_dmem_arb;

  localparam int XL      = 31;
  localparam int MAX_OUT = 2;

  logic        g_clk = 1'b0;
  logic        g_reset;

  logic        m0_req, m0_wen, m0_ack;
  logic [3:0]  m0_strb;
  logic [31:0] m0_addr, m0_wdata;
  logic        m0_gnt, m0_recv, m0_error;
  logic [31:0] m0_rdata;

  logic        m1_req, m1_wen, m1_ack;
  logic [3:0]  m1_strb;
  logic [31:0] m1_addr, m1_wdata;
  logic        m1_gnt, m1_recv, m1_error;
  logic [31:0] m1_rdata;

  logic        dmem_req, dmem_wen, dmem_ack;
  logic [3:0]  dmem_strb;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_gnt, dmem_recv, dmem_error;
  logic [31:0] dmem_rdata;

  always #5 g_clk = ~g_clk;

  frv_dmem_arb #(.XL(XL), .MAX_OUT(MAX_OUT)) dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .m0_req(m0_req), .m0_wen(m0_wen), .m0_strb(m0_strb), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_recv(m0_recv), .m0_ack(m0_ack),
    .m0_error(m0_error), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wen(m1_wen), .m1_strb(m1_strb), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_recv(m1_recv), .m1_ack(m1_ack),
    .m1_error(m1_error), .m1_rdata(m1_rdata),
    .dmem_req(dmem_req), .dmem_wen(dmem_wen), .dmem_strb(dmem_strb),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_recv(dmem_recv), .dmem_ack(dmem_ack), .dmem_error(dmem_error),
    .dmem_rdata(dmem_rdata)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit rr_mode;
  int held;        // -1: no master held, else the held master
  bit owners[$];   // issuers of outstanding transactions, oldest first
  bit pref;        // round-robin preferred master

  bit e_s, e_sreq, e_req, e_acc, e_ack, e_r0, e_r1;

  task automatic model_reset();
    held = -1;
    owners.delete();
    pref = 1'b0;
  endtask

  task automatic model_eval();
    if (held >= 0)             e_s = (held == 1);
    else if (m0_req && m1_req) e_s = rr_mode ? pref : 1'b0;
    else                       e_s = m1_req;
    e_sreq = e_s ? m1_req : m0_req;
    e_req  = e_sreq && (owners.size() < MAX_OUT);
    e_acc  = e_req && dmem_gnt;
    if (owners.size() == 0) begin
      e_ack = dmem_recv;
      e_r0  = 1'b0;
      e_r1  = 1'b0;
    end else begin
      e_ack = owners[0] ? m1_ack : m0_ack;
      e_r0  = dmem_recv && !owners[0];
      e_r1  = dmem_recv && owners[0];
    end
  endtask

  task automatic model_check();
    model_eval();
    check_eq("dmem_req", dmem_req, e_req);
    check_eq("m0_gnt", m0_gnt, e_acc && !e_s);
    check_eq("m1_gnt", m1_gnt, e_acc && e_s);
    check_eq("dmem_ack", dmem_ack, e_ack);
    check_eq("m0_recv", m0_recv, e_r0);
    check_eq("m1_recv", m1_recv, e_r1);
    check_eq("m0_error", m0_error, e_r0 && dmem_error);
    check_eq("m1_error", m1_error, e_r1 && dmem_error);
    check_eq("m0_rdata", m0_rdata, e_r0 ? dmem_rdata : 32'h0);
    check_eq("m1_rdata", m1_rdata, e_r1 ? dmem_rdata : 32'h0);
    if (e_req) begin
      check_eq("dmem_addr", dmem_addr, e_s ? m1_addr : m0_addr);
      check_eq("dmem_wdata", dmem_wdata, e_s ? m1_wdata : m0_wdata);
      check_eq("dmem_strb", {28'h0, dmem_strb}, {28'h0, e_s ? m1_strb : m0_strb});
      check_eq("dmem_wen", dmem_wen, e_s ? m1_wen : m0_wen);
    end
  endtask

  task automatic model_update();
    if (g_reset) begin
      model_reset();
    end else begin
      if (dmem_recv && e_ack && owners.size() > 0) void'(owners.pop_front());
      if (e_acc) owners.push_back(e_s);
      if (rr_mode && e_acc && e_s == pref) pref = !pref;
      if (held < 0) begin
        if (e_sreq && !e_acc) held = e_s ? 1 : 0;
      end else if (!e_sreq || e_acc) begin
        held = -1;
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic set_idle();
    g_reset = 1'b0;
    m0_req = 0; m0_wen = 0; m0_strb = 0; m0_addr = 0; m0_wdata = 0; m0_ack = 0;
    m1_req = 0; m1_wen = 0; m1_strb = 0; m1_addr = 0; m1_wdata = 0; m1_ack = 0;
    dmem_gnt = 0; dmem_recv = 0; dmem_error = 0; dmem_rdata = 0;
  endtask

  // Sample in the low phase; inputs are changed just after the rising edge.
  task automatic settle();
    @(negedge g_clk);
    model_check();
  endtask

  task automatic advance();
    model_update();
    @(posedge g_clk);
    #1;
  endtask

  task automatic cyc();
    settle();
    advance();
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_outs"},
             {25'h0, dmem_req, dmem_wen, dmem_ack, m0_gnt, m1_gnt, m0_recv, m1_recv},
             32'h0);
    check_eq({tag, "_err"}, {30'h0, m0_error, m1_error}, 32'h0);
    check_eq({tag, "_addr"}, dmem_addr | dmem_wdata | {28'h0, dmem_strb}, 32'h0);
    check_eq({tag, "_rdata"}, m0_rdata | m1_rdata, 32'h0);
  endtask

  initial begin
`ifdef FRV_DMEM_ARB_RR_EN
    rr_mode = 1'b1;
`else
    rr_mode = 1'b0;
`endif
    set_idle();
    model_reset();
    g_reset = 1'b1;
    @(posedge g_clk);
    #1;
    cyc();
    set_idle();
    settle();
    check_all_zero("reset");
    advance();

    // Simultaneous requests: priority winner first, then m1; in-order responses.
    m0_req = 1; m0_addr = 32'h40; m1_req = 1; m1_addr = 32'h80; dmem_gnt = 1;
    settle();
    check_eq("tie_m0_gnt", m0_gnt, 1'b1);
    check_eq("tie_m1_gnt", m1_gnt, 1'b0);
    advance();
    m0_req = 0;
    settle();
    check_eq("tie_next_m1_gnt", m1_gnt, 1'b1);
    advance();
    set_idle();
    dmem_recv = 1; dmem_rdata = 32'h1111_0000; m0_ack = 1; m1_ack = 1;
    settle();
    check_eq("resp_first_m0", m0_recv, 1'b1);
    advance();
    dmem_rdata = 32'h2222_0000;
    settle();
    check_eq("resp_second_m1", m1_recv, 1'b1);
    advance();
    set_idle();

    // m1 stalls at 0x100 while m0 joins: the selection must stay on m1.
    m1_req = 1; m1_addr = 32'h100; m1_wen = 1; m1_wdata = 32'hCAFE_0001; m1_strb = 4'hF;
    cyc();
    m0_req = 1; m0_addr = 32'h200;
    for (int i = 0; i < 3; i++) begin
      settle();
      check_eq("lock_addr", dmem_addr, 32'h100);
      check_eq("lock_no_m0_gnt", m0_gnt, 1'b0);
      advance();
    end
    dmem_gnt = 1;
    settle();
    check_eq("lock_m1_gnt", m1_gnt, 1'b1);
    advance();
    m1_req = 0;
    settle();
    check_eq("after_lock_m0_gnt", m0_gnt, 1'b1);
    advance();

    // Two outstanding: the third request is held off until a response pops.
    settle();
    check_eq("full_blocks_req", dmem_req, 1'b0);
    advance();
    dmem_recv = 1; m1_ack = 1; dmem_rdata = 32'h3;
    settle();
    check_eq("full_pop_cycle_req", dmem_req, 1'b0);
    advance();
    dmem_recv = 0; m1_ack = 0;
    settle();
    check_eq("req_after_pop", dmem_req, 1'b1);
    advance();

    // Error response to m0 held until m0 acks.
    set_idle();
    dmem_recv = 1; dmem_error = 1; dmem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      settle();
      check_eq("err_m0_recv", m0_recv, 1'b1);
      check_eq("err_m0_error", m0_error, 1'b1);
      check_eq("err_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
      check_eq("err_m1_recv", m1_recv, 1'b0);
      check_eq("err_no_ack", dmem_ack, 1'b0);
      advance();
    end
    m0_ack = 1;
    cyc();
    cyc();
    set_idle();

    // Reset with one transaction outstanding and LOCK0 active.
    m0_req = 1; m0_addr = 32'h300; dmem_gnt = 1;
    cyc();
    dmem_gnt = 0;
    cyc();
    set_idle();
    g_reset = 1;
    cyc();
    set_idle();
    settle();
    check_all_zero("midreset");
    advance();
    dmem_recv = 1; dmem_rdata = 32'h5555_AAAA;
    settle();
    check_eq("spurious_ack", dmem_ack, 1'b1);
    check_eq("spurious_no_m0", m0_recv, 1'b0);
    advance();
    set_idle();

    // Both masters requesting continuously.
    m0_req = 1; m1_req = 1; dmem_gnt = 1; dmem_recv = 1; m0_ack = 1; m1_ack = 1;
    for (int i = 0; i < 4; i++) begin
      settle();
      check_eq("cont_m0_gnt", m0_gnt, rr_mode ? ((i % 2) == 0) : 1'b1);
      check_eq("cont_m1_gnt", m1_gnt, rr_mode ? ((i % 2) == 1) : 1'b0);
      advance();
    end
    set_idle();

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      g_reset    = ($urandom_range(0, 59) == 0);
      m0_req     = ($urandom_range(0, 9) < 6);
      m1_req     = ($urandom_range(0, 9) < 5);
      m0_wen     = $urandom; m1_wen = $urandom;
      m0_strb    = 4'($urandom); m1_strb = 4'($urandom);
      m0_addr    = $urandom; m1_addr = $urandom;
      m0_wdata   = $urandom; m1_wdata = $urandom;
      m0_ack     = ($urandom_range(0, 3) != 0);
      m1_ack     = ($urandom_range(0, 3) != 0);
      dmem_gnt   = ($urandom_range(0, 2) != 0);
      dmem_recv  = ($urandom_range(0, 1) != 0);
      dmem_error = ($urandom_range(0, 5) == 0);
      dmem_rdata = $urandom;
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
